spi_flash_arbiter: RTL
======================

Name: spi_flash_arbiter

Overview:
Shares one spi_flash_top instance between two requesters.
- Instruction-fetch port: 32-bit XIP reads.
- Command port: byte read, byte program, sector erase.
Sits between the core's fetch unit / flash-control peripheral and spi_flash_top. It sequences the flash request/ack handshakes and assembles fetch words.

Parameters:
IFETCH_PRIO, 0: 0 = round-robin arbitration; 1 = fixed priority, ifetch wins.
WP_TOP, 24'h010000: first writable byte address; used only with the optional feature.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
ifetch_req  in  1  fetch request; held until ifetch_ack
ifetch_addr  in  24  fetch byte address; bits [1:0] ignored (treated as 0)
ifetch_rdata  out  32  fetched word, little-endian; valid in ifetch_ack cycle
ifetch_ack  out  1  one-cycle completion pulse
cmd_req  in  1  command request; held until cmd_ack
cmd_op  in  2  0 = read byte, 1 = program byte, 2 = sector erase, 3 = reserved
cmd_addr  in  24  command byte address
cmd_wdata  in  8  program data
cmd_rdata  out  8  read byte; valid in cmd_ack cycle
cmd_ack  out  1  one-cycle completion pulse
cmd_err  out  1  valid with cmd_ack; 1 = rejected, no flash activity
flash_read  out  1  to spi_flash_top
flash_write  out  1  to spi_flash_top
flash_sector_erase  out  1  to spi_flash_top
flash_read_addr  out  24  to spi_flash_top
flash_write_addr  out  24  to spi_flash_top
flash_sector_addr  out  24  to spi_flash_top
flash_write_data_in  out  8  to spi_flash_top
flash_read_size  out  9  to spi_flash_top
flash_write_size  out  9  to spi_flash_top; constant 1
flash_read_ack  in  1  from spi_flash_top
flash_write_ack  in  1  from spi_flash_top
flash_sector_erase_ack  in  1  from spi_flash_top
flash_write_data_req  in  1  from spi_flash_top
flash_read_data_out  in  8  from spi_flash_top
flash_read_data_valid  in  1  from spi_flash_top

Behaviour:
- Reset values:
  - All outputs 0, except flash_read_size = 1 and flash_write_size = 1.
  - FSM in S_IDLE; last_grant = cmd.
  - Reset mid-operation aborts immediately. spi_flash_top shares the reset source.
- States: S_IDLE, S_FETCH, S_CMD_RD, S_CMD_PP, S_CMD_SE, S_DONE.
- S_IDLE:
  - Samples requests and registers the granted operands.
  - Next cycle: the matching flash_* request is 1, or S_DONE for a rejected command.
- Arbitration with both requests pending:
  - IDLE cycle, IFETCH_PRIO=1: ifetch wins.
  - IFETCH_PRIO=0: grant goes to the port not in last_grant; last_grant updates on every grant.
  - A single pending request is always granted.
- S_FETCH:
  - flash_read_addr = {addr[23:2], 2'b00}; flash_read_size = 4; flash_read held at 1.
  - 2-bit byte counter: each flash_read_data_valid writes flash_read_data_out into byte lane n, then n increments.
  - On flash_read_ack: drop flash_read, go to S_DONE.
- S_CMD_RD:
  - flash_read_size = 1; flash_read_addr = cmd_addr.
  - Byte is captured on valid; flash_read_ack → S_DONE.
- S_CMD_PP:
  - flash_write_addr = cmd_addr; flash_write_data_in = latched cmd_wdata, stable for the whole state.
  - flash_write held until flash_write_ack → S_DONE.
- S_CMD_SE:
  - flash_sector_addr = {cmd_addr[23:12], 12'h000}.
  - flash_sector_erase held until flash_sector_erase_ack → S_DONE.
- cmd_op=3: IDLE → S_DONE directly with cmd_err=1; no flash request.
- S_DONE:
  - Pulses ifetch_ack or cmd_ack (matching the grant) for exactly one cycle; rdata/err valid in that cycle.
  - Returns to S_IDLE. Requests are not sampled in S_DONE.
  - Latency: ack rises 2 cycles after the flash ack (flash ack → S_DONE registered → ack output registered). It is fixed; the bench checks it exactly.
- Requesters drop req in the cycle after ack. A req still high in the following S_IDLE cycle is a new request.
- At most one flash_* request is high at any time.
- Flash ack inputs that arrive in a state not expecting them are ignored.

Optional Feature:
SPI_FLASH_ARB_WP_EN
- Defined: cmd_op 1 or 2 with cmd_addr < WP_TOP is rejected: S_DONE with cmd_err=1, no flash request. For erase, the check uses the sector-aligned address.
- Undefined: no write protection; WP_TOP unused; cmd_err is 1 only for cmd_op=3.

Test Plan:
- Fetch 0x000102: flash_read_addr = 0x000100, size = 4. Model returns AA,BB,CC,DD → ifetch_rdata = 32'hDDCCBBAA, one ifetch_ack pulse.
- cmd read 0x123456 returning 8'h5A → cmd_rdata = 8'h5A, cmd_err = 0; flash_read_size = 1 during the transaction.
- Program 0x020010 with 8'h3C → flash_write_addr = 0x020010, flash_write_data_in = 8'h3C at every flash_write_data_req. Sector erase 0x020FFF → flash_sector_addr = 0x020000.
- Both requests high every cycle, IFETCH_PRIO=0, cmd_op=0 → grants alternate fetch/cmd. IFETCH_PRIO=1 → fetch is granted every time while ifetch_req is held.
- cmd_op = 3 → cmd_ack with cmd_err = 1 and no flash_* request. With WP_EN, program to 0x00FFFF → err = 1; program to 0x010000 → proceeds.
- rst_n low mid-S_FETCH after 2 valid bytes → all outputs 0 immediately. After release, a new fetch completes correctly.

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Arbitrates a single spi_flash_top between a 32-bit XIP fetch port and a byte command port.
// Define SPI_FLASH_ARB_WP_EN to reject program/erase below WP_TOP.
module spi_flash_arbiter #(
  parameter bit          IFETCH_PRIO = 1'b0,
  parameter logic [23:0] WP_TOP      = 24'h010000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifetch_req,
  input  logic [23:0] ifetch_addr,
  output logic [31:0] ifetch_rdata,
  output logic        ifetch_ack,
  input  logic        cmd_req,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic [7:0]  cmd_rdata,
  output logic        cmd_ack,
  output logic        cmd_err,
  output logic        flash_read,
  output logic        flash_write,
  output logic        flash_sector_erase,
  output logic [23:0] flash_read_addr,
  output logic [23:0] flash_write_addr,
  output logic [23:0] flash_sector_addr,
  output logic [7:0]  flash_write_data_in,
  output logic [8:0]  flash_read_size,
  output logic [8:0]  flash_write_size,
  input  logic        flash_read_ack,
  input  logic        flash_write_ack,
  input  logic        flash_sector_erase_ack,
  input  logic        flash_write_data_req,
  input  logic [7:0]  flash_read_data_out,
  input  logic        flash_read_data_valid
);

  // state    | meaning
  // S_IDLE   | sample requests, latch operands of the granted port
  // S_FETCH  | 4-byte flash read, bytes packed little-endian
  // S_CMD_RD | 1-byte flash read
  // S_CMD_PP | 1-byte program
  // S_CMD_SE | sector erase
  // S_DONE   | schedule the one-cycle ack to the granted port
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CMD_RD, S_CMD_PP, S_CMD_SE, S_DONE
  } state_t;

`ifdef SPI_FLASH_ARB_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        last_cmd_q, grant_cmd_q, err_q;
  logic [23:0] addr_q;
  logic [7:0]  wdata_q, rbyte_q;
  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic        take_fetch, take_cmd, wp_hit, cmd_reject;

  // The ack cycle is spent in S_IDLE; requests seen there belong to the finished transfer.
  always_comb begin
    take_fetch = 1'b0;
    take_cmd   = 1'b0;
    if (state_q == S_IDLE && !(ifetch_ack || cmd_ack)) begin
      if (ifetch_req && cmd_req) begin
        if (IFETCH_PRIO || last_cmd_q) take_fetch = 1'b1;
        else                           take_cmd   = 1'b1;
      end else if (ifetch_req) begin
        take_fetch = 1'b1;
      end else if (cmd_req) begin
        take_cmd = 1'b1;
      end
    end
  end

  assign wp_hit = WP_EN &&
                  (((cmd_op == 2'd1) && (cmd_addr < WP_TOP)) ||
                   ((cmd_op == 2'd2) && ({cmd_addr[23:12], 12'h000} < WP_TOP)));
  assign cmd_reject = (cmd_op == 2'd3) || wp_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    flash_read         = 1'b0;
    flash_write        = 1'b0;
    flash_sector_erase = 1'b0;
    flash_read_size    = 9'd1;
    case (state_q)
      S_IDLE: begin
        if (take_fetch) begin
          state_d = S_FETCH;
        end else if (take_cmd) begin
          if (cmd_reject)          state_d = S_DONE;
          else if (cmd_op == 2'd0) state_d = S_CMD_RD;
          else if (cmd_op == 2'd1) state_d = S_CMD_PP;
          else                     state_d = S_CMD_SE;
        end
      end
      S_FETCH: begin
        flash_read      = 1'b1;
        flash_read_size = 9'd4;
        if (flash_read_ack) state_d = S_DONE;
      end
      S_CMD_RD: begin
        flash_read = 1'b1;
        if (flash_read_ack) state_d = S_DONE;
      end
      S_CMD_PP: begin
        flash_write = 1'b1;
        if (flash_write_ack) state_d = S_DONE;
      end
      S_CMD_SE: begin
        flash_sector_erase = 1'b1;
        if (flash_sector_erase_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cmd_q  <= 1'b1;
      grant_cmd_q <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbyte_q     <= '0;
      word_q      <= '0;
      cnt_q       <= '0;
      ifetch_ack  <= 1'b0;
      cmd_ack     <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      if (take_fetch) begin
        addr_q      <= ifetch_addr & 24'hFFFFFC;
        grant_cmd_q <= 1'b0;
        last_cmd_q  <= 1'b0;
        err_q       <= 1'b0;
        cnt_q       <= '0;
      end else if (take_cmd) begin
        addr_q      <= cmd_addr;
        wdata_q     <= cmd_wdata;
        grant_cmd_q <= 1'b1;
        last_cmd_q  <= 1'b1;
        err_q       <= cmd_reject;
      end
      if (state_q == S_FETCH && flash_read_data_valid) begin
        word_q[{cnt_q, 3'b000} +: 8] <= flash_read_data_out;
        cnt_q <= cnt_q + 2'd1;
      end
      if (state_q == S_CMD_RD && flash_read_data_valid) rbyte_q <= flash_read_data_out;
      ifetch_ack <= (state_q == S_DONE) && !grant_cmd_q;
      cmd_ack    <= (state_q == S_DONE) && grant_cmd_q;
      cmd_err    <= (state_q == S_DONE) && grant_cmd_q && err_q;
    end
  end

  assign ifetch_rdata        = word_q;
  assign cmd_rdata           = rbyte_q;
  assign flash_read_addr     = addr_q;
  assign flash_write_addr    = addr_q;
  assign flash_sector_addr   = {addr_q[23:12], 12'h000};
  assign flash_write_data_in = wdata_q;
  assign flash_write_size    = 9'd1;

endmodule
